// File: rtl/priority_scan_encoder_pkg.sv
// Shared definitions for the priority scan encoder.
//   state_e : two-state controller encoding (ST_IDLE, ST_SCAN).
package priority_scan_encoder_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

endpackage

// File: rtl/priority_scan_encoder_prio_enc.sv
// Combinational priority encoder, generalised replacement for the 8-to-4 encoder.
//   i_vec : input vector (WIDTH bits)
//   o_idx : index of the winning set bit (0 when the vector is empty)
//   o_any : 1 when any bit of i_vec is set
// MSB_FIRST=1 selects the highest set bit, MSB_FIRST=0 the lowest.
module prio_enc
    import priority_scan_encoder_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int IDX_W    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // The last matching bit in loop order wins, so loop direction sets priority.
    always_comb begin
        o_idx = '0;
        o_any = |i_vec;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (i_vec[i]) o_idx = IDX_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (i_vec[i]) o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/priority_scan_encoder.sv
// Sequential priority scan encoder: captures a request vector and emits the
// index of each set bit, one beat per accepted handshake, in priority order.
//   i_clk, i_rst_n      : clock, async active-low reset
//   i_flush             : synchronous abort, overrides every other event
//   i_valid/o_ready/i_vec : input vector handshake
//   o_valid/i_ready     : output beat handshake
//   o_idx, o_idx_valid  : current index and whether it refers to a set bit
//   o_last              : final beat of the current vector
//   o_count             : popcount of the captured vector
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | ready for a new vector, no beat presented
// ST_SCAN | presenting beats from the pending mask until o_last is taken
module priority_scan_encoder
    import priority_scan_encoder_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int IDX_W     = $clog2(WIDTH),
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_vec,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_idx_valid,
    output logic             o_last,
    output logic [IDX_W:0]   o_count
);

    function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + (IDX_W + 1)'(v[i]);
        end
        return c;
    endfunction

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   pend_q, pend_d;
    logic [IDX_W:0]     count_q, count_d;

    logic [IDX_W-1:0]   enc_idx;
    logic               enc_any;
    logic [IDX_W:0]     pend_cnt;
    logic [WIDTH-1:0]   clr_mask;

    prio_enc #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_prio_enc (
        .i_vec (pend_q),
        .o_idx (enc_idx),
        .o_any (enc_any)
    );

    assign pend_cnt = popcount(pend_q);
    assign clr_mask = WIDTH'(1) << enc_idx;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        count_d     = count_q;
        o_ready     = (state_q == ST_IDLE);
        o_valid     = (state_q == ST_SCAN);
        o_idx       = enc_idx;
        // Gated by state so both flags read 0 while idle (pending mask is empty there).
        o_idx_valid = o_valid & enc_any;
        o_last      = o_valid & (pend_cnt <= (IDX_W + 1)'(1));

        if (i_flush) begin
            state_d = ST_IDLE;
            pend_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        pend_d  = i_vec;
                        count_d = popcount(i_vec);
                        state_d = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (i_ready) begin
                        // Clearing bit 0 of an empty mask is harmless, so the empty beat needs no special case.
                        pend_d = pend_q & ~clr_mask;
                        if (o_last) state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

// File: tb/tb_priority_scan_encoder.sv
module tb_priority_scan_encoder;

    typedef struct {
        logic [1:0]      sel;
        logic [7:0]      vec;
        int              nbeats;
        logic [3:0]      count;
        logic [7:0][2:0] idxs;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] vec = '0;
    logic       rdy = 1'b0;
    logic [1:0] sel = 2'd0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // DUT a: WIDTH=8 MSB first; DUT b: WIDTH=8 LSB first; DUT c: WIDTH=5 MSB first
    logic       a_ready, a_valid, a_iv, a_last;
    logic [2:0] a_idx;
    logic [3:0] a_cnt;
    logic       b_ready, b_valid, b_iv, b_last;
    logic [2:0] b_idx;
    logic [3:0] b_cnt;
    logic       c_ready, c_valid, c_iv, c_last;
    logic [2:0] c_idx;
    logic [3:0] c_cnt;

    logic valid_a, valid_b, valid_c;
    assign valid_a = in_valid && (sel == 2'd0);
    assign valid_b = in_valid && (sel == 2'd1);
    assign valid_c = in_valid && (sel == 2'd2);

    priority_scan_encoder #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid_a),
        .o_ready(a_ready), .i_vec(vec), .o_valid(a_valid), .i_ready(rdy),
        .o_idx(a_idx), .o_idx_valid(a_iv), .o_last(a_last), .o_count(a_cnt));

    priority_scan_encoder #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid_b),
        .o_ready(b_ready), .i_vec(vec), .o_valid(b_valid), .i_ready(rdy),
        .o_idx(b_idx), .o_idx_valid(b_iv), .o_last(b_last), .o_count(b_cnt));

    priority_scan_encoder #(.WIDTH(5), .MSB_FIRST(1'b1)) u_dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid_c),
        .o_ready(c_ready), .i_vec(vec[4:0]), .o_valid(c_valid), .i_ready(rdy),
        .o_idx(c_idx), .o_idx_valid(c_iv), .o_last(c_last), .o_count(c_cnt));

    logic       o_ready, o_valid, o_iv, o_last;
    logic [2:0] o_idx;
    logic [3:0] o_cnt;

    always_comb begin
        o_ready = a_ready; o_valid = a_valid; o_iv = a_iv;
        o_last  = a_last;  o_idx   = a_idx;   o_cnt = a_cnt;
        case (sel)
            2'd1: begin
                o_ready = b_ready; o_valid = b_valid; o_iv = b_iv;
                o_last  = b_last;  o_idx   = b_idx;   o_cnt = b_cnt;
            end
            2'd2: begin
                o_ready = c_ready; o_valid = c_valid; o_iv = c_iv;
                o_last  = c_last;  o_idx   = c_idx;   o_cnt = c_cnt;
            end
            default: ;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vector(input vec_t t);
        sel = t.sel;
        @(negedge clk);
        chk("accept_ready", 32'(o_ready), 32'd1);
        vec = t.vec;
        in_valid = 1'b1;
        rdy = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int b = 0; b < t.nbeats; b++) begin
            chk("beat_valid", 32'(o_valid), 32'd1);
            chk("beat_idx", 32'(o_idx), 32'(t.idxs[b]));
            chk("beat_idx_valid", 32'(o_iv), 32'(t.count != 4'd0));
            chk("beat_last", 32'(o_last), 32'(b == t.nbeats - 1));
            chk("beat_count", 32'(o_cnt), 32'(t.count));
            @(negedge clk);
        end
        chk("post_ready", 32'(o_ready), 32'd1);
        chk("post_valid", 32'(o_valid), 32'd0);
    endtask

    vec_t tbl[9];

    initial begin
        // idxs are listed last-beat-first: idxs[0] is the first beat
        tbl[0] = '{sel: 2'd0, vec: 8'b1010_0110, nbeats: 4, count: 4'd4,
                   idxs: {3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd5, 3'd7}};
        tbl[1] = '{sel: 2'd1, vec: 8'b1010_0110, nbeats: 4, count: 4'd4,
                   idxs: {3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd5, 3'd2, 3'd1}};
        tbl[2] = '{sel: 2'd0, vec: 8'h00, nbeats: 1, count: 4'd0, idxs: '0};
        tbl[3] = '{sel: 2'd0, vec: 8'h01, nbeats: 1, count: 4'd1, idxs: '0};
        tbl[4] = '{sel: 2'd0, vec: 8'h80, nbeats: 1, count: 4'd1,
                   idxs: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7}};
        tbl[5] = '{sel: 2'd1, vec: 8'h00, nbeats: 1, count: 4'd0, idxs: '0};
        tbl[6] = '{sel: 2'd2, vec: 8'b0001_0001, nbeats: 2, count: 4'd2,
                   idxs: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4}};
        tbl[7] = '{sel: 2'd2, vec: 8'b0001_1111, nbeats: 5, count: 4'd5,
                   idxs: {3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4}};
        tbl[8] = '{sel: 2'd1, vec: 8'h81, nbeats: 2, count: 4'd2,
                   idxs: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd0}};

        // reset state of all three instances
        #12 rst_n = 1'b1;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            @(negedge clk);
            chk("rst_ready", 32'(o_ready), 32'd1);
            chk("rst_valid", 32'(o_valid), 32'd0);
            chk("rst_idx", 32'(o_idx), 32'd0);
            chk("rst_idx_valid", 32'(o_iv), 32'd0);
            chk("rst_last", 32'(o_last), 32'd0);
            chk("rst_count", 32'(o_cnt), 32'd0);
        end

        for (int i = 0; i < 9; i++) run_vector(tbl[i]);

        // 8'hFF with i_ready pattern 1,0,0 repeating: stalled beats must hold
        begin
            int e;
            sel = 2'd0;
            @(negedge clk);
            vec = 8'hFF; in_valid = 1'b1; rdy = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            e = 0;
            for (int cyc = 0; cyc < 40 && e < 8; cyc++) begin
                logic r;
                chk("stall_valid", 32'(o_valid), 32'd1);
                chk("stall_idx", 32'(o_idx), 32'(7 - e));
                chk("stall_last", 32'(o_last), 32'(e == 7));
                chk("stall_count", 32'(o_cnt), 32'd8);
                r = (cyc % 3 == 0);
                rdy = r;
                @(posedge clk);
                if (r) e++;
                @(negedge clk);
            end
            chk("stall_beats", 32'(e), 32'd8);
            chk("stall_done_ready", 32'(o_ready), 32'd1);
            rdy = 1'b1;
        end

        // flush during the 2nd beat of 8'b1100_0011
        sel = 2'd0;
        @(negedge clk);
        vec = 8'b1100_0011; in_valid = 1'b1; rdy = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("fl_beat1", 32'(o_idx), 32'd7);
        @(negedge clk);
        chk("fl_beat2", 32'(o_idx), 32'd6);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_valid", 32'(o_valid), 32'd0);
        chk("fl_ready", 32'(o_ready), 32'd1);
        chk("fl_count_hold", 32'(o_cnt), 32'd4);
        run_vector('{sel: 2'd0, vec: 8'h10, nbeats: 1, count: 4'd1,
                     idxs: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4}});

        // flush wins over a same-cycle vector in IDLE
        @(negedge clk);
        vec = 8'h0F; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("fl_idle_valid", 32'(o_valid), 32'd0);
        chk("fl_idle_ready", 32'(o_ready), 32'd1);
        chk("fl_idle_count", 32'(o_cnt), 32'd1);

        // async reset mid-scan
        vec = 8'hFF; in_valid = 1'b1; rdy = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ar_valid_before", 32'(o_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid_drop", 32'(o_valid), 32'd0);
        chk("ar_ready", 32'(o_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_post_ready", 32'(o_ready), 32'd1);
        chk("ar_post_count", 32'(o_cnt), 32'd0);
        chk("ar_post_valid", 32'(o_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
